// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: opcodes, control bundle, ID/EX datapath bundle.
package riscv_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;

    // Control signals produced by the decode controller
    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic [1:0] aluop;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Operand/datapath fields carried from ID into EX
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
    } data_t;

    // Control only survives into EX for a valid instruction
    function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
        return valid ? c : CTRL_NOP;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in EX and the one in ID.
module hazard_detect (
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       flush,
    input  logic       hold,
    output logic       load_use,
    output logic       stall
);

    // A load writing x0 never produces a value worth waiting for
    always_comb begin
        load_use = ex_valid & ex_memread & (ex_rd != 5'd0) & id_valid &
                   ((ex_rd == id_rs1) | (ex_rd == id_rs2));
        // Flush kills the consumer and hold freezes everything, so neither needs a stall
        stall    = load_use & ~flush & ~hold;
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and bubble counter.
module id_ex_pipe
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rd1,
    input  logic [31:0] id_rd2,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [2:0]  id_funct3,
    input  logic        id_funct7b5,
    input  logic        id_alusrc,
    input  logic        id_memtoreg,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic [1:0]  id_aluop,
    input  logic        id_branch,
    input  logic        flush,
    input  logic        hold,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rd1,
    output logic [31:0] ex_rd2,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_funct3,
    output logic        ex_funct7b5,
    output logic        ex_alusrc,
    output logic        ex_memtoreg,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic [1:0]  ex_aluop,
    output logic        ex_branch,
    output logic        stall,
    output logic [15:0] bubble_cnt
);

    logic        valid_q, valid_d;
    ctrl_t       ctrl_q, ctrl_d;
    data_t       data_q, data_d;
    logic [15:0] cnt_q, cnt_d;

    ctrl_t       id_ctrl;
    data_t       id_data;
    logic        load_use;

    assign id_ctrl = '{
        alusrc:   id_alusrc,
        memtoreg: id_memtoreg,
        regwrite: id_regwrite,
        memread:  id_memread,
        memwrite: id_memwrite,
        aluop:    id_aluop,
        branch:   id_branch
    };

    assign id_data = '{
        pc:       id_pc,
        rd1:      id_rd1,
        rd2:      id_rd2,
        imm:      id_imm,
        rs1:      id_rs1,
        rs2:      id_rs2,
        rd:       id_rd,
        funct3:   id_funct3,
        funct7b5: id_funct7b5
    };

    hazard_detect u_hazard_detect (
        .ex_valid   (valid_q),
        .ex_memread (ctrl_q.memread),
        .ex_rd      (data_q.rd),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .flush      (flush),
        .hold       (hold),
        .load_use   (load_use),
        .stall      (stall)
    );

    // Next-state: flush beats hold beats load-use; datapath tracks ID whenever not held
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (flush || (!hold && load_use)) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
            cnt_d   = cnt_q + 16'd1;
        end else if (!hold) begin
            valid_d = id_valid;
            ctrl_d  = gate_ctrl(id_ctrl, id_valid);
        end
        // Datapath contents under a bubble are don't-care, so skip the extra mux term
        if (!hold) begin
            data_d = id_data;
        end
    end

    // State registers with synchronous reset dominating every other action
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            data_q  <= '0;
            cnt_q   <= 16'd0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output unpacking
    always_comb begin
        ex_valid    = valid_q;
        ex_alusrc   = ctrl_q.alusrc;
        ex_memtoreg = ctrl_q.memtoreg;
        ex_regwrite = ctrl_q.regwrite;
        ex_memread  = ctrl_q.memread;
        ex_memwrite = ctrl_q.memwrite;
        ex_aluop    = ctrl_q.aluop;
        ex_branch   = ctrl_q.branch;
        ex_pc       = data_q.pc;
        ex_rd1      = data_q.rd1;
        ex_rd2      = data_q.rd2;
        ex_imm      = data_q.imm;
        ex_rs1      = data_q.rs1;
        ex_rs2      = data_q.rs2;
        ex_rd       = data_q.rd;
        ex_funct3   = data_q.funct3;
        ex_funct7b5 = data_q.funct7b5;
        bubble_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed scenarios plus randomized run against a model.
module tb_id_ex_pipe;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        alusrc;
        logic        memtoreg;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic [1:0]  aluop;
        logic        branch;
    } instr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic   reset = 1'b1;
    logic   flush = 1'b0;
    logic   hold  = 1'b0;
    instr_t id_in = '0;

    logic        ex_valid, ex_funct7b5, ex_alusrc, ex_memtoreg, ex_regwrite;
    logic        ex_memread, ex_memwrite, ex_branch, stall;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_aluop;
    logic [15:0] bubble_cnt;

    // Model: the instruction currently in EX, whether its datapath is defined, bubble count
    instr_t      m_ex = '0;
    logic        m_known = 1'b1;
    logic [15:0] m_cnt = 16'd0;

    int checks = 0;
    int errors = 0;

    logic [8:0]   obs_ctl;
    logic [146:0] obs_data;
    assign obs_ctl  = {ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite,
                       ex_aluop, ex_branch};
    assign obs_data = {ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3,
                       ex_funct7b5};

    id_ex_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_in.valid),
        .id_pc       (id_in.pc),
        .id_rd1      (id_in.rd1),
        .id_rd2      (id_in.rd2),
        .id_imm      (id_in.imm),
        .id_rs1      (id_in.rs1),
        .id_rs2      (id_in.rs2),
        .id_rd       (id_in.rd),
        .id_funct3   (id_in.funct3),
        .id_funct7b5 (id_in.funct7b5),
        .id_alusrc   (id_in.alusrc),
        .id_memtoreg (id_in.memtoreg),
        .id_regwrite (id_in.regwrite),
        .id_memread  (id_in.memread),
        .id_memwrite (id_in.memwrite),
        .id_aluop    (id_in.aluop),
        .id_branch   (id_in.branch),
        .flush       (flush),
        .hold        (hold),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_rd1      (ex_rd1),
        .ex_rd2      (ex_rd2),
        .ex_imm      (ex_imm),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_rd       (ex_rd),
        .ex_funct3   (ex_funct3),
        .ex_funct7b5 (ex_funct7b5),
        .ex_alusrc   (ex_alusrc),
        .ex_memtoreg (ex_memtoreg),
        .ex_regwrite (ex_regwrite),
        .ex_memread  (ex_memread),
        .ex_memwrite (ex_memwrite),
        .ex_aluop    (ex_aluop),
        .ex_branch   (ex_branch),
        .stall       (stall),
        .bubble_cnt  (bubble_cnt)
    );

    function automatic logic [8:0] ctl_of(input instr_t i);
        return {i.valid, i.alusrc, i.memtoreg, i.regwrite, i.memread, i.memwrite, i.aluop,
                i.branch};
    endfunction

    function automatic logic [146:0] data_of(input instr_t i);
        return {i.pc, i.rd1, i.rd2, i.imm, i.rs1, i.rs2, i.rd, i.funct3, i.funct7b5};
    endfunction

    // An empty EX slot: nothing valid, no control asserted
    function automatic instr_t kill(input instr_t i);
        instr_t k = i;
        k.valid = 1'b0; k.alusrc = 1'b0; k.memtoreg = 1'b0; k.regwrite = 1'b0;
        k.memread = 1'b0; k.memwrite = 1'b0; k.aluop = 2'b00; k.branch = 1'b0;
        return k;
    endfunction

    // The ID consumer reads a register the EX load has not produced yet
    function automatic logic model_load_use();
        return m_ex.valid && m_ex.memread && (m_ex.rd != 5'd0) && id_in.valid &&
               (m_ex.rd == id_in.rs1 || m_ex.rd == id_in.rs2);
    endfunction

    function automatic logic model_stall();
        return model_load_use() && !flush && !hold;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid    = ($urandom_range(0, 7) != 0);
        i.pc       = $urandom;
        i.rd1      = $urandom;
        i.rd2      = $urandom;
        i.imm      = $urandom;
        i.rs1      = 5'($urandom_range(0, 3));
        i.rs2      = 5'($urandom_range(0, 3));
        i.rd       = 5'($urandom_range(0, 3));
        i.funct3   = 3'($urandom);
        i.funct7b5 = 1'($urandom);
        i.alusrc   = 1'($urandom);
        i.memtoreg = 1'($urandom);
        i.regwrite = 1'($urandom);
        i.memread  = ($urandom_range(0, 2) == 0);
        i.memwrite = 1'($urandom);
        i.aluop    = 2'($urandom);
        i.branch   = 1'($urandom);
        return i;
    endfunction

    // One clock edge, advancing the model from the inputs seen just before the edge
    task automatic tick();
        instr_t pre = id_in;
        logic   lu  = model_load_use();
        logic   r   = reset;
        logic   f   = flush;
        logic   h   = hold;
        @(posedge clk);
        if (r) begin
            m_ex    = '0;
            m_cnt   = 16'd0;
            m_known = 1'b1;
        end else if (f || (!h && lu)) begin
            m_ex    = kill(m_ex);
            m_cnt   = m_cnt + 16'd1;
            m_known = 1'b0;
        end else if (!h) begin
            m_ex    = pre.valid ? pre : kill(pre);
            m_known = 1'b1;
        end
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; flush = 1'b0; hold = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    function automatic instr_t make_load(input logic [4:0] rd);
        instr_t i = '0;
        i.valid = 1'b1; i.memread = 1'b1; i.memtoreg = 1'b1; i.regwrite = 1'b1;
        i.alusrc = 1'b1; i.rd = rd; i.rs1 = 5'd2; i.rs2 = 5'd9; i.pc = 32'h100;
        i.imm = 32'h10; i.funct3 = 3'b010;
        return i;
    endfunction

    function automatic instr_t make_add(input logic [4:0] rs1, input logic [4:0] rs2);
        instr_t i = '0;
        i.valid = 1'b1; i.regwrite = 1'b1; i.aluop = 2'b10; i.rs1 = rs1; i.rs2 = rs2;
        i.rd = 5'd6; i.pc = 32'h104; i.rd1 = 32'hDEAD_0001; i.rd2 = 32'hBEEF_0002;
        return i;
    endfunction

    task automatic test_reset();
        instr_t i = rand_instr();
        i.valid = 1'b1; i.regwrite = 1'b1;
        id_in = i; reset = 1'b1; flush = 1'b0; hold = 1'b0;
        tick();
        tick();
        checks++;
        if (obs_ctl !== 9'd0) begin
            errors++; $display("FAIL reset_ctl: got %h expected 000", obs_ctl);
        end
        checks++;
        if (obs_data !== 147'd0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", obs_data);
        end
        checks++;
        if (bubble_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_cnt: got %h expected 0000", bubble_cnt);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b expected 0", stall);
        end
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        instr_t ld  = make_load(5'd5);
        instr_t add = make_add(5'd5, 5'd1);
        apply_reset();
        id_in = ld;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL lu_stall_pre: got %b expected 0", stall);
        end
        tick();
        checks++;
        if (obs_ctl !== ctl_of(ld) || obs_data !== data_of(ld)) begin
            errors++; $display("FAIL lu_load: got %h/%h expected %h/%h", obs_ctl, obs_data,
                               ctl_of(ld), data_of(ld));
        end
        id_in = add;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL lu_stall: got %b expected 1", stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || obs_ctl !== 9'd0 || bubble_cnt !== 16'd1) begin
            errors++; $display("FAIL lu_bubble: got ctl %h cnt %0d expected ctl 000 cnt 1",
                               obs_ctl, bubble_cnt);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL lu_stall_drop: got %b expected 0", stall);
        end
        tick();
        checks++;
        if (obs_ctl !== ctl_of(add) || obs_data !== data_of(add) || bubble_cnt !== 16'd1) begin
            errors++; $display("FAIL lu_add: got %h/%h cnt %0d expected %h/%h cnt 1", obs_ctl,
                               obs_data, bubble_cnt, ctl_of(add), data_of(add));
        end
    endtask

    task automatic test_x0();
        instr_t ld  = make_load(5'd0);
        instr_t use0 = make_add(5'd0, 5'd0);
        apply_reset();
        id_in = ld;
        tick();
        id_in = use0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL x0_stall: got %b expected 0", stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || bubble_cnt !== 16'd0 || obs_data !== data_of(use0)) begin
            errors++; $display("FAIL x0_load: got valid %b cnt %0d expected valid 1 cnt 0",
                               ex_valid, bubble_cnt);
        end
    endtask

    task automatic test_flush_lu();
        instr_t ld  = make_load(5'd5);
        instr_t add = make_add(5'd1, 5'd5);
        apply_reset();
        id_in = ld;
        tick();
        id_in = add; flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL fl_stall: got %b expected 0", stall);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (obs_ctl !== 9'd0 || bubble_cnt !== 16'd1) begin
            errors++; $display("FAIL fl_bubble: got ctl %h cnt %0d expected ctl 000 cnt 1",
                               obs_ctl, bubble_cnt);
        end
        tick();
        checks++;
        if (obs_ctl !== ctl_of(add) || bubble_cnt !== 16'd1) begin
            errors++; $display("FAIL fl_next: got ctl %h cnt %0d expected ctl %h cnt 1",
                               obs_ctl, bubble_cnt, ctl_of(add));
        end
    endtask

    task automatic test_hold();
        instr_t       ld = make_load(5'd3);
        logic [8:0]   snap_ctl;
        logic [146:0] snap_data;
        apply_reset();
        id_in = ld;
        tick();
        snap_ctl  = ctl_of(ld);
        snap_data = data_of(ld);
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            id_in = rand_instr();
            id_in.valid = 1'b1; id_in.rs1 = 5'd3; id_in.pc = 32'h200 + 32'(c);
            #1;
            checks++;
            if (stall !== 1'b0) begin
                errors++; $display("FAIL hold_stall[%0d]: got %b expected 0", c, stall);
            end
            tick();
            checks++;
            if (obs_ctl !== snap_ctl || obs_data !== snap_data || bubble_cnt !== 16'd0) begin
                errors++; $display("FAIL hold_keep[%0d]: got %h/%h cnt %0d expected %h/%h cnt 0",
                                   c, obs_ctl, obs_data, bubble_cnt, snap_ctl, snap_data);
            end
        end
        hold = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL hold_reeval: got %b expected 1", stall);
        end
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 500; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 5) == 0);
            id_in = rand_instr();
            #1;
            checks++;
            if (stall !== model_stall()) begin
                errors++; $display("FAIL rnd_stall[%0d]: got %b expected %b", n, stall,
                                   model_stall());
            end
            tick();
            checks++;
            if (obs_ctl !== ctl_of(m_ex) || bubble_cnt !== m_cnt) begin
                errors++; $display("FAIL rnd_ctl[%0d]: got %h cnt %0d expected %h cnt %0d", n,
                                   obs_ctl, bubble_cnt, ctl_of(m_ex), m_cnt);
            end
            if (m_known) begin
                checks++;
                if (obs_data !== data_of(m_ex)) begin
                    errors++; $display("FAIL rnd_data[%0d]: got %h expected %h", n, obs_data,
                                       data_of(m_ex));
                end
            end
        end
        reset = 1'b0; flush = 1'b0; hold = 1'b0;
    endtask

    task automatic test_wrap();
        apply_reset();
        id_in = rand_instr();
        flush = 1'b1;
        for (int n = 0; n < 65535; n++) tick();
        checks++;
        if (bubble_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_max: got %h expected ffff", bubble_cnt);
        end
        tick();
        checks++;
        if (bubble_cnt !== 16'h0000) begin
            errors++; $display("FAIL wrap_zero: got %h expected 0000", bubble_cnt);
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_flush_lu();
        test_hold();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these ID-side inputs: id_valid 1, id_pc 32, id_rd1 32, id_rd2 32, id_imm 32, id_rs1 5, id_rs2 5, id_rd 5, id_funct3 3, id_funct7b5 1.
REQ-003 The block SHALL have these ID-side control inputs from the decode controller: id_alusrc 1, id_memtoreg 1, id_regwrite 1, id_memread 1, id_memwrite 1, id_aluop 2, id_branch 1.
REQ-004 The block SHALL have these sideband inputs: flush  in  1  branch taken, kill the ID instruction; hold  in  1  global freeze, e.g. memory wait.
REQ-005 The block SHALL have an EX-side output registered counterpart for every REQ-002/REQ-003 input, prefixed ex_ (e.g. ex_valid, ex_rd, ex_aluop).
REQ-006 The block SHALL have these outputs: stall  out  1  combinational, freeze PC and IF/ID; bubble_cnt  out  16  count of inserted bubbles.

Function
REQ-007 A load-use hazard SHALL be load_use = ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
REQ-008 The stall output SHALL be load_use & ~flush & ~hold.
REQ-009 On each rising clk edge, the first true condition SHALL decide the action:
  - reset -> bubble.
  - flush -> bubble.
  - hold -> keep all ex_ registers unchanged.
  - load_use -> bubble.
  - otherwise -> load all ID inputs.
REQ-010 A bubble SHALL set ex_valid and all seven ex_ control outputs to 0.
REQ-011 During a bubble, the ex_ datapath registers (pc, rd1, rd2, imm, rs1, rs2, rd, funct3, funct7b5) SHALL be don't-care, but SHALL be cleared to 0 on reset.
REQ-012 A load SHALL copy the ID inputs verbatim, with one-cycle latency, and with control gated: an ex_ control bit SHALL be id_control & id_valid.
REQ-013 A load-use hazard SHALL insert exactly one bubble. On the next cycle ex_memread is 0, so stall SHALL deassert and the held instruction SHALL load.
REQ-014 A hazard SHALL NOT be raised against rd=x0, or when ex_valid=0.
REQ-015 bubble_cnt SHALL increment by 1 on each bubble caused by flush or load_use, SHALL NOT increment on reset, and SHALL wrap from 0xFFFF to 0.
REQ-016 When flush and load_use coincide, the block SHALL insert one bubble, deassert stall, and increment bubble_cnt by 1.
REQ-017 When hold and load_use coincide, the registers SHALL be unchanged and stall SHALL be 0, so the hazard is re-evaluated after hold.

Reset
REQ-018 When reset is high at a clk edge, all ex_ outputs and bubble_cnt SHALL be 0 on the following cycle.
REQ-019 reset SHALL take priority over flush, hold and load_use.
REQ-020 While reset is high, stall SHALL follow REQ-008 but have no effect, because ex_valid=0.
REQ-021 A reset asserted mid-stall SHALL discard the stalled instruction's EX copy; no recovery state is kept.

Structure
REQ-022 A shared package riscv_pkg SHALL hold:
  - the opcode constants (R_TYPE 0110011, I_TYPE 0010011, LUI 0110111, LW 0000011, SW 0100011, BR 1100011);
  - typedef ctrl_t, a packed struct of the seven control signals;
  - constant CTRL_NOP, all zero.
REQ-023 Internally, the control registers SHALL be a single ctrl_t.
REQ-024 Hazard detection SHALL be a combinational sub-module, hazard_detect, that implements REQ-007/REQ-008 and is instantiated once.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
  - Scenario 1: reset=1 for 2 cycles with id_valid=1, id_regwrite=1 -> ex_valid=0, ex_regwrite=0, bubble_cnt=0.
  - Scenario 2: load x5 (memread=1, rd=5), then add with rs1=5 -> stall=1 for exactly 1 cycle, one bubble (ex_valid=0), add appears in EX the following cycle, bubble_cnt=1.
  - Scenario 3: load with rd=0, then instruction with rs2=0 -> stall never asserts, no bubble.
  - Scenario 4: load_use and flush in the same cycle -> stall=0, one bubble, bubble_cnt increments by exactly 1.
  - Scenario 5: hold=1 for 3 cycles with changing ID inputs -> ex_ outputs constant, stall=0, bubble_cnt unchanged.
  - Scenario 6: preload bubble_cnt to 0xFFFF via 65535 flushes, then 1 flush -> bubble_cnt=0x0000.
